f2fx_conv_12: RTL
=================

# f2fx_conv_12

Pipelined converter from the 12-bit floating-point format produced by the adder datapath to signed fixed-point. The 12-bit format is sign[11], exponent[10:6] with bias 15, and mantissa[5:0] with a hidden leading 1. The block sits on the output side of the float arithmetic, where results leave the float domain and feed fixed-point consumers (memory write-back, activation tables). It has a three-stage pipeline with a valid/ready handshake on both sides and a global stall.

## Interface
Parameters:
- OUT_W, default 16: output width in bits, two's complement. Legal range is 9..32.
- FRAC_W, default 8: fractional bits of the output. Legal range is 0..OUT_W-2.

Ports:
- clk_i, input, 1: clock. One clock domain; reset is synchronous and active-high.
- rst_i, input, 1: synchronous active-high reset.
- valid_i, input, 1: input word present.
- ready_o, output, 1: block accepts input this cycle.
- data_i, input, 12: float input {sgn, exp[4:0], man[5:0]}.
- valid_o, output, 1: output word present.
- ready_i, input, 1: downstream accepts output.
- data_o, output, OUT_W: signed fixed-point result with FRAC_W fractional bits.
- sat_o, output, 1: qualified by valid_o. High when data_o was clamped.
- sat_sticky_o, output, 1: OR of every sat_o transfer since the last reset.

## Operation
- **Value definition.** value = (-1)^sgn × (64+man)/64 × 2^(exp-15).
  - Target result: value × 2^FRAC_W, rounded or truncated per Configuration, then saturated.
- **Zero.** If exp == 0, data_o = 0 and sat_o = 0, regardless of man and sgn (flush-to-zero). Negative zero also produces 0.
- **Infinity/saturation code.** If exp == 31, data_o saturates by sign and sat_o = 1.
- **Saturation values.** Saturation is symmetric:
  - positive: +(2^(OUT_W-1)-1)
  - negative: -(2^(OUT_W-1)-1)
- **Stage 1:** register sgn, zero flag, the 7-bit significand M = {1,man}, and the signed shift s = exp - 21 + FRAC_W (7-bit signed).
- **Stage 2:** compute magnitude.
  - s ≥ 0, overflow: if s > OUT_W-8, set the overflow flag.
  - s ≥ 0, no overflow: mag = M << s.
  - s < 0, s ≥ -8: mag = M >> -s. Rounding adds bit (-s-1) of M.
  - s < -8: mag = 0.
  - Rounding never overflows for legal parameters.
- **Stage 3:** apply sign by two's complement negation of mag. On overflow or exp == 31, apply the saturation value instead. Register data_o and sat_o.
- **Handshake.** stall = valid_o & ~ready_i. ready_o = ~stall.
  - A transfer occurs on either side when valid & ready are both high in the same cycle.
  - While stall is high, all three stages hold: data, valids and flags.
  - Bubbles propagate as valid = 0 and are not compressed.
  - valid_i is sampled only when ready_o = 1. The upstream block must hold data_i stable while valid_i=1 & ready_o=0.

## Timing
- **Latency.** 3 cycles from input acceptance to valid_o, when there is no stall. Throughput is 1 word per cycle.
- **Stall resume.** After a stall, the first transfer resumes in the same cycle ready_i rises. There is no lost or duplicated word.
- **Reset values.** valid_o = 0, data_o = 0, sat_o = 0, sat_sticky_o = 0. All stage valids are 0.
- **Reset during operation.** Reset mid-stream discards all in-flight words. ready_o = 1 in the first cycle after reset.
- **Reset priority.** Reset takes priority over stall.
- **Sticky flag timing.** sat_sticky_o updates in the cycle after the saturated transfer.

## Configuration
- **F2FX_ROUND_EN defined:** round-half-up on right shifts (add the first discarded bit). Rounding is applied to the magnitude, so negative values round away from zero symmetrically.
- **F2FX_ROUND_EN not defined:** truncate the magnitude (toward zero). The rounding adder is removed.

## Test plan
- **Single positive input.** OUT_W=16, FRAC_W=8, data_i=0x3C0 (1.0) -> data_o=0x0100 after 3 cycles, sat_o=0.
- **Negative input.** data_i=0xC10 (-2.5) -> data_o=0xFD80. Also data_i=0x800 (negative zero) -> 0x0000.
- **Saturation, exponent overflow.** data_i=0x580 (exp 22, +128.0) -> 0x7FFF with sat_o=1.
- **Saturation, exp 31.** data_i=0xFC0 (exp 31, negative) -> 0x8001 with sat_o=1. sat_sticky_o stays high until rst_i.
- **Rounding.** data_i=0x1E0 (1.5 LSB):
  - with F2FX_ROUND_EN -> 0x0002
  - without -> 0x0001
  - data_i=0x040 (exp 1) -> 0x0000
- **Back-to-back with stall.** Send 6 words back-to-back while holding ready_i=0 for cycles 4-7 -> ready_o=0 during the stall. All 6 outputs appear in order, unchanged, none dropped. Asserting rst_i mid-stall -> valid_o=0 next cycle and no stale word appears afterward.

Source files
------------

// File: rtl/f2fx_conv_12.sv
// f2fx_conv_12: three-stage pipelined converter from the 12-bit float format
// {sgn, exp[4:0] (bias 15), man[5:0] (hidden 1)} to OUT_W-bit signed fixed
// point with FRAC_W fractional bits. Results are clamped symmetrically.
// Optional feature macro: F2FX_ROUND_EN (round-half-up on right shifts);
// when undefined the magnitude is truncated toward zero.
module f2fx_conv_12 #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [11:0]      data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o,
    output logic             sat_sticky_o
);

    // Largest left shift that still fits the 7-bit significand in OUT_W-1 bits.
    localparam int              SHIFT_MAX = OUT_W - 8;
    localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

    // Global stall: the whole pipeline freezes while the output is blocked.
    logic stall;

    // Stage 1 registers: unpacked operand.
    logic       s1_valid_q, s1_valid_d;
    logic       s1_sgn_q,   s1_sgn_d;
    logic       s1_zero_q,  s1_zero_d;
    logic       s1_inf_q,   s1_inf_d;
    logic [6:0] s1_man_q,   s1_man_d;
    logic [6:0] s1_shift_q, s1_shift_d;   // two's complement shift amount

    // Stage 2 registers: unsigned magnitude and saturation request.
    logic             s2_valid_q, s2_valid_d;
    logic             s2_sgn_q,   s2_sgn_d;
    logic             s2_sat_q,   s2_sat_d;
    logic [OUT_W-1:0] s2_mag_q,   s2_mag_d;

    // Stage 3 registers: signed result presented on the output.
    logic             valid_o_q,    valid_o_d;
    logic [OUT_W-1:0] data_o_q,     data_o_d;
    logic             sat_o_q,      sat_o_d;
    logic             sat_sticky_q, sat_sticky_d;

    // Stage-2 working signals.
    logic       shift_neg;
    logic [6:0] rshift;
`ifdef F2FX_ROUND_EN
    logic [7:0] man_ext;
    logic       round_bit;
`endif

    assign stall        = valid_o_q & ~ready_i;
    assign ready_o      = ~stall;
    assign valid_o      = valid_o_q;
    assign data_o       = data_o_q;
    assign sat_o        = sat_o_q;
    assign sat_sticky_o = sat_sticky_q;

    // Stage 1: split the float word and compute the signed shift exp - 21 + FRAC_W.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        s1_valid_d = valid_i;
        s1_sgn_d   = data_i[11];
        s1_zero_d  = (data_i[10:6] == 5'd0);
        s1_inf_d   = (data_i[10:6] == 5'd31);
        s1_man_d   = {1'b1, data_i[5:0]};
        // Modulo-128 add gives the correct 7-bit two's complement result.
        s1_shift_d = {2'b00, data_i[10:6]} + 7'(FRAC_W - 21);
    end

    // Stage 2: shift the significand into place, rounding or truncating right shifts.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sgn_d   = s1_sgn_q;
        s2_sat_d   = 1'b0;
        s2_mag_d   = '0;
        shift_neg  = s1_shift_q[6];
        rshift     = ~s1_shift_q + 7'd1;
`ifdef F2FX_ROUND_EN
        man_ext    = {1'b0, s1_man_q};
        round_bit  = 1'b0;
`endif
        if (s1_zero_q) begin
            // Flush-to-zero wins over every other case, including sign.
            s2_mag_d = '0;
            s2_sat_d = 1'b0;
        end else if (s1_inf_q) begin
            s2_sat_d = 1'b1;
        end else if (!shift_neg) begin
            if (s1_shift_q > 7'(SHIFT_MAX)) begin
                s2_sat_d = 1'b1;
            end else begin
                s2_mag_d = OUT_W'(s1_man_q) << s1_shift_q;
            end
        end else if (rshift <= 7'd8) begin
            s2_mag_d = OUT_W'(s1_man_q >> rshift);
`ifdef F2FX_ROUND_EN
            // Add the first discarded bit; the result stays far below OUT_W-1 bits.
            round_bit = man_ext[3'(rshift - 7'd1)];
            s2_mag_d  = s2_mag_d + OUT_W'(round_bit);
`endif
        end else begin
            s2_mag_d = '0;
        end
    end

    // Stage 3: apply the sign or the symmetric clamp, and track sticky saturation.
    always_comb begin
        valid_o_d = s2_valid_q;
        sat_o_d   = s2_sat_q;
        if (s2_sat_q) begin
            data_o_d = s2_sgn_q ? SAT_NEG : SAT_POS;
        end else if (s2_sgn_q) begin
            data_o_d = ~s2_mag_q + 1'b1;
        end else begin
            data_o_d = s2_mag_q;
        end
        sat_sticky_d = sat_sticky_q | (valid_o_q & ready_i & sat_o_q);
    end

    // Pipeline registers: reset clears everything, stall holds every stage.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst_i) begin
            // NOTE: datapath registers are reset too, so data_o reads 0 after
            // reset and no stale operand can reach the output.
            s1_valid_q   <= 1'b0;
            s1_sgn_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_man_q     <= '0;
            s1_shift_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_sgn_q     <= 1'b0;
            s2_sat_q     <= 1'b0;
            s2_mag_q     <= '0;
            valid_o_q    <= 1'b0;
            data_o_q     <= '0;
            sat_o_q      <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            // A transfer cannot happen while stalled, so the sticky flag may update freely.
            sat_sticky_q <= sat_sticky_d;
            if (!stall) begin
                s1_valid_q <= s1_valid_d;
                s1_sgn_q   <= s1_sgn_d;
                s1_zero_q  <= s1_zero_d;
                s1_inf_q   <= s1_inf_d;
                s1_man_q   <= s1_man_d;
                s1_shift_q <= s1_shift_d;
                s2_valid_q <= s2_valid_d;
                s2_sgn_q   <= s2_sgn_d;
                s2_sat_q   <= s2_sat_d;
                s2_mag_q   <= s2_mag_d;
                valid_o_q  <= valid_o_d;
                data_o_q   <= data_o_d;
                sat_o_q    <= sat_o_d;
            end
        end
    end

endmodule
